// File: rtl/iso7816_activation_ctrl.sv
// iso7816_activation_ctrl
// Interface-device sequencer for an ISO 7816-3 contact set: cold activation,
// warm reset and deactivation, plus ATR start-bit window checking.
// All outputs are registered; contact outputs trail the state by one cycle.
module iso7816_activation_ctrl #(
    parameter int unsigned PWR_CYCLES = 16,
    parameter int unsigned TA_CYCLES  = 200,
    parameter int unsigned TB_CYCLES  = 400,
    parameter int unsigned ATR_MIN    = 400,
    parameter int unsigned ATR_MAX    = 40000,
    parameter int unsigned CNT_W      = 16
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_cmd_activate,
    input  logic       i_cmd_warm_reset,
    input  logic       i_cmd_deactivate,
    input  logic       i_io,
    output logic       o_vcc_en,
    output logic       o_clk_en,
    output logic       o_card_rst,
    output logic       o_io_rel,
    output logic       o_active,
    output logic       o_busy,
    output logic       o_done,
    output logic [1:0] o_err,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PWRUP   = 3'd1,
        ST_RSTLOW  = 3'd2,
        ST_ATRWAIT = 3'd3,
        ST_ACTIVE  = 3'd4,
        ST_DEACT   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE        = 2'd0,
        ERR_IO_LOW      = 2'd1,
        ERR_ATR_EARLY   = 2'd2,
        ERR_ATR_TIMEOUT = 2'd3
    } err_e;

    // Timer compare points, sized to the timer so every compare is same-width.
    localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(PWR_CYCLES - 1);
    localparam logic [CNT_W-1:0] TA_LAST    = CNT_W'(TA_CYCLES - 1);
    localparam logic [CNT_W-1:0] TB_LAST    = CNT_W'(TB_CYCLES - 1);
    localparam logic [CNT_W-1:0] ATR_MIN_C  = CNT_W'(ATR_MIN);
    localparam logic [CNT_W-1:0] ATR_MAX_C  = CNT_W'(ATR_MAX);
    localparam logic [CNT_W-1:0] DEACT_LAST = CNT_W'(3);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               io_hi_q, io_hi_d;
    logic               io_prev_q;
    err_e               err_q, err_d;

    logic               vcc_en_q, vcc_en_d;
    logic               clk_en_q, clk_en_d;
    logic               card_rst_q, card_rst_d;
    logic               io_rel_q, io_rel_d;
    logic               active_q, active_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               act_ok;
    logic               warm_ok;
    logic               deact_ok;
    logic               start_bit;
    logic               io_seen;

    // Commands are only honoured in the states that can act on them; the
    // state sets are disjoint except ACTIVE, where deactivate wins below.
    assign act_ok    = i_cmd_activate && (state_q == ST_IDLE);
    assign warm_ok   = i_cmd_warm_reset && (state_q == ST_ACTIVE);
    assign deact_ok  = i_cmd_deactivate && (state_q != ST_IDLE) && (state_q != ST_DEACT);
    assign start_bit = io_prev_q && !i_io;
    assign io_seen   = io_hi_q || i_io;

    // State register, shared timer, sticky IO-high flag and IO edge history.
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
    // so the order of statements in clocked blocks never matters.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            io_hi_q   <= 1'b0;
            io_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            io_hi_q   <= io_hi_d;
            io_prev_q <= i_io;
        end
    end

    // Next-state, error code and timer update.
    // NOTE: every variable gets a default at the top of a combinational block;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (act_ok) begin
                    state_d = ST_PWRUP;
                    err_d   = ERR_NONE;
                end
            end
            ST_PWRUP: begin
                if (cnt_q == PWR_LAST) state_d = ST_RSTLOW;
            end
            ST_RSTLOW: begin
                if ((cnt_q == TA_LAST) && !io_seen) begin
                    err_d   = ERR_IO_LOW;
                    state_d = ST_DEACT;
                end else if (cnt_q == TB_LAST) begin
                    state_d = ST_ATRWAIT;
                end
            end
            ST_ATRWAIT: begin
                // A start bit is checked first so one landing on the timeout
                // cycle still counts as a valid ATR.
                if (start_bit) begin
                    if (cnt_q < ATR_MIN_C) begin
                        err_d   = ERR_ATR_EARLY;
                        state_d = ST_DEACT;
                    end else begin
                        state_d = ST_ACTIVE;
                    end
                end else if (cnt_q == ATR_MAX_C) begin
                    err_d   = ERR_ATR_TIMEOUT;
                    state_d = ST_DEACT;
                end
            end
            ST_ACTIVE: begin
                if (warm_ok) state_d = ST_RSTLOW;
            end
            ST_DEACT: begin
                if (cnt_q == DEACT_LAST) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Deactivate overrides everything, but an error raised this same
        // cycle is kept so the host still sees why the card failed.
        if (deact_ok) state_d = ST_DEACT;

        if (state_d != state_q) begin
            cnt_d   = '0;
            io_hi_d = 1'b0;
        end else begin
            cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
            io_hi_d = io_hi_q || ((state_q == ST_RSTLOW) && i_io);
        end
    end

    // Output decode: contacts from the current state, status from the next.
    always_comb begin
        vcc_en_d   = 1'b0;
        clk_en_d   = 1'b0;
        card_rst_d = 1'b0;
        io_rel_d   = 1'b0;
        unique case (state_q)
            ST_PWRUP: begin
                vcc_en_d = 1'b1;
            end
            ST_RSTLOW: begin
                vcc_en_d = 1'b1;
                clk_en_d = 1'b1;
                io_rel_d = 1'b1;
            end
            ST_ATRWAIT, ST_ACTIVE: begin
                vcc_en_d   = 1'b1;
                clk_en_d   = 1'b1;
                io_rel_d   = 1'b1;
                card_rst_d = 1'b1;
            end
            ST_DEACT: begin
                // Contacts drop one per cycle in RST, CLK, IO, VCC order; a
                // contact that was never raised stays low.
                clk_en_d = clk_en_q && (cnt_q < CNT_W'(1));
                io_rel_d = io_rel_q && (cnt_q < CNT_W'(2));
                vcc_en_d = vcc_en_q && (cnt_q < CNT_W'(3));
            end
            default: ;
        endcase

        active_d = (state_d == ST_ACTIVE);
        busy_d   = (state_d != ST_IDLE) && (state_d != ST_ACTIVE);
        done_d   = (state_d == ST_ACTIVE) && (state_q != ST_ACTIVE);
    end

    // Output registers, so no command reaches a pin combinationally.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            vcc_en_q   <= 1'b0;
            clk_en_q   <= 1'b0;
            card_rst_q <= 1'b0;
            io_rel_q   <= 1'b0;
            active_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= ERR_NONE;
        end else begin
            vcc_en_q   <= vcc_en_d;
            clk_en_q   <= clk_en_d;
            card_rst_q <= card_rst_d;
            io_rel_q   <= io_rel_d;
            active_q   <= active_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign o_vcc_en   = vcc_en_q;
    assign o_clk_en   = clk_en_q;
    assign o_card_rst = card_rst_q;
    assign o_io_rel   = io_rel_q;
    assign o_active   = active_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_err      = err_q;
    assign o_state    = state_q;

endmodule

// File: tb/tb_iso7816_activation_ctrl.sv
// tb_iso7816_activation_ctrl
// Directed bench: expected output snapshots are queued when stimulus is
// applied and popped when the corresponding cycle is sampled (on negedge).
`timescale 1ns/1ps
module tb_iso7816_activation_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rstn = 1'b0;
    logic       i_cmd_activate = 1'b0;
    logic       i_cmd_warm_reset = 1'b0;
    logic       i_cmd_deactivate = 1'b0;
    logic       i_io = 1'b0;
    logic       o_vcc_en;
    logic       o_clk_en;
    logic       o_card_rst;
    logic       o_io_rel;
    logic       o_active;
    logic       o_busy;
    logic       o_done;
    logic [1:0] o_err;
    logic [2:0] o_state;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   active_cycles = 0;
    int   base;

    iso7816_activation_ctrl dut (
        .i_clk            (i_clk),
        .i_rstn           (i_rstn),
        .i_cmd_activate   (i_cmd_activate),
        .i_cmd_warm_reset (i_cmd_warm_reset),
        .i_cmd_deactivate (i_cmd_deactivate),
        .i_io             (i_io),
        .o_vcc_en         (o_vcc_en),
        .o_clk_en         (o_clk_en),
        .o_card_rst       (o_card_rst),
        .o_io_rel         (o_io_rel),
        .o_active         (o_active),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_err            (o_err),
        .o_state          (o_state)
    );

    always #5 i_clk = ~i_clk;

    // Count cycles with o_active high, to prove it never rose in a test.
    always @(negedge i_clk) begin
        if (o_active === 1'b1) active_cycles <= active_cycles + 1;
    end

    // Safety net so the run always ends.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "bench did not finish");
    end

    // {vcc, clk, rst, io_rel, active, busy, done, err[1:0], state[2:0]}
    function automatic logic [15:0] mk(input logic vcc, input logic clk,
                                       input logic rst, input logic rel,
                                       input logic act, input logic busy,
                                       input logic done, input logic [1:0] err,
                                       input logic [2:0] st);
        return {4'b0, vcc, clk, rst, rel, act, busy, done, err, st};
    endfunction

    function automatic logic [15:0] snap();
        return {4'b0, o_vcc_en, o_clk_en, o_card_rst, o_io_rel,
                o_active, o_busy, o_done, o_err, o_state};
    endfunction

    task automatic push(input string tag, input logic [15:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic check(input logic [15:0] obs);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed=%0h required=none", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed=%0h required=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    // Drive commands for exactly one rising edge, starting from a negedge.
    task automatic pulse(input logic a, input logic w, input logic d);
        i_cmd_activate   = a;
        i_cmd_warm_reset = w;
        i_cmd_deactivate = d;
        @(negedge i_clk);
        i_cmd_activate   = 1'b0;
        i_cmd_warm_reset = 1'b0;
        i_cmd_deactivate = 1'b0;
    endtask

    initial begin
        // Reset
        step(3);
        i_rstn = 1'b1;
        push("reset_values", 16'h0);
        check(snap());
        step(5);

        // Cold activation, normal card
        push("pwrup_entry", mk(0,0,0,0, 0,1,0,2'd0,3'd1));
        pulse(1, 0, 0);
        check(snap());
        push("vcc_on", mk(1,0,0,0, 0,1,0,2'd0,3'd1));
        step(1);
        check(snap());
        push("rstlow_entry", mk(1,0,0,0, 0,1,0,2'd0,3'd2));
        step(15);
        check(snap());
        push("clk_on", mk(1,1,0,1, 0,1,0,2'd0,3'd2));
        step(1);
        check(snap());
        step(49);
        i_io = 1'b1;
        push("atrwait_entry", mk(1,1,0,1, 0,1,0,2'd0,3'd3));
        step(350);
        check(snap());
        push("card_rst_high", mk(1,1,1,1, 0,1,0,2'd0,3'd3));
        step(1);
        check(snap());
        step(999);
        i_io = 1'b0;
        push("atr_done", mk(1,1,1,1, 1,0,1,2'd0,3'd4));
        step(1);
        check(snap());
        i_io = 1'b1;
        push("done_one_cycle", mk(1,1,1,1, 1,0,0,2'd0,3'd4));
        step(1);
        check(snap());

        // Activate while ACTIVE is ignored
        push("act_ignored", mk(1,1,1,1, 1,0,0,2'd0,3'd4));
        pulse(1, 0, 0);
        check(snap());
        push("act_ignored_later", mk(1,1,1,1, 1,0,0,2'd0,3'd4));
        step(2);
        check(snap());

        // Warm reset
        push("warm_entry", mk(1,1,1,1, 0,1,0,2'd0,3'd2));
        pulse(0, 1, 0);
        check(snap());
        push("warm_rst_low", mk(1,1,0,1, 0,1,0,2'd0,3'd2));
        step(1);
        check(snap());
        push("warm_rst_still_low", mk(1,1,0,1, 0,1,0,2'd0,3'd3));
        step(399);
        check(snap());
        push("warm_rst_high", mk(1,1,1,1, 0,1,0,2'd0,3'd3));
        step(1);
        check(snap());
        step(500);
        i_io = 1'b0;
        push("warm_atr_done", mk(1,1,1,1, 1,0,1,2'd0,3'd4));
        step(1);
        check(snap());
        i_io = 1'b1;
        step(2);

        // Warm reset and deactivate together: deactivate wins
        push("prio_deact", mk(1,1,1,1, 0,1,0,2'd0,3'd5));
        pulse(0, 1, 1);
        check(snap());
        push("deact_step_rst", mk(1,1,0,1, 0,1,0,2'd0,3'd5));
        step(1);
        check(snap());
        push("deact_step_clk", mk(1,0,0,1, 0,1,0,2'd0,3'd5));
        step(1);
        check(snap());
        push("deact_step_io", mk(1,0,0,0, 0,1,0,2'd0,3'd5));
        step(1);
        check(snap());
        push("deact_step_vcc", mk(0,0,0,0, 0,0,0,2'd0,3'd0));
        step(1);
        check(snap());

        // IO stuck low
        i_io = 1'b0;
        step(3);
        pulse(1, 0, 0);
        push("stuck_before_ta", mk(1,1,0,1, 0,1,0,2'd0,3'd2));
        step(215);
        check(snap());
        push("stuck_err", mk(1,1,0,1, 0,1,0,2'd1,3'd5));
        step(1);
        check(snap());
        push("stuck_deact_rst", mk(1,1,0,1, 0,1,0,2'd1,3'd5));
        step(1);
        check(snap());
        push("stuck_deact_clk", mk(1,0,0,1, 0,1,0,2'd1,3'd5));
        step(1);
        check(snap());
        push("stuck_deact_io", mk(1,0,0,0, 0,1,0,2'd1,3'd5));
        step(1);
        check(snap());
        push("stuck_idle", mk(0,0,0,0, 0,0,0,2'd1,3'd0));
        step(1);
        check(snap());

        // Warm reset / deactivate in IDLE are ignored; error is held
        push("idle_cmds_ignored", mk(0,0,0,0, 0,0,0,2'd1,3'd0));
        pulse(0, 1, 1);
        check(snap());

        // Early ATR
        base = active_cycles;
        push("early_act_clears_err", mk(0,0,0,0, 0,1,0,2'd0,3'd1));
        pulse(1, 0, 0);
        check(snap());
        step(66);
        i_io = 1'b1;
        push("early_in_atrwait", mk(1,1,1,1, 0,1,0,2'd0,3'd3));
        step(450);
        check(snap());
        step(1);
        i_io = 1'b0;
        push("early_err", mk(1,1,1,1, 0,1,0,2'd2,3'd5));
        step(1);
        check(snap());
        push("early_idle", mk(0,0,0,0, 0,0,0,2'd2,3'd0));
        step(4);
        check(snap());
        push("early_no_active", 16'h0);
        check(16'(active_cycles - base));

        // ATR timeout
        pulse(1, 0, 0);
        step(66);
        i_io = 1'b1;
        push("timeout_atrwait_entry", mk(1,1,0,1, 0,1,0,2'd0,3'd3));
        step(350);
        check(snap());
        push("timeout_last_wait", mk(1,1,1,1, 0,1,0,2'd0,3'd3));
        step(40000);
        check(snap());
        push("timeout_err", mk(1,1,1,1, 0,1,0,2'd3,3'd5));
        step(1);
        check(snap());
        push("timeout_idle", mk(0,0,0,0, 0,0,0,2'd3,3'd0));
        step(4);
        check(snap());

        // Asynchronous reset while in ATRWAIT
        pulse(1, 0, 0);
        push("async_in_atrwait", mk(1,1,1,1, 0,1,0,2'd0,3'd3));
        step(516);
        check(snap());
        #2;
        i_rstn = 1'b0;
        #1;
        push("async_reset_outputs", 16'h0);
        check(snap());
        @(negedge i_clk);
        i_rstn = 1'b1;
        push("after_reset_idle", 16'h0);
        step(2);
        check(snap());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iso7816_activation_ctrl.md
# iso7816_activation_ctrl

Interface-device-side sequencer for an ISO 7816-3 card contact set. It runs cold activation, warm reset and deactivation by driving VCC enable, card clock enable, the card RST line and the IO release. It checks the card's ATR start-bit window and reports completion or an error code. It sits between the host register block and the IO UART/pad logic; the UART may use the IO line only while `o_active` is high.

## Interface
Parameters:
- `PWR_CYCLES`, 16: clocks VCC is stable before the card clock starts.
- `TA_CYCLES`, 200: maximum clocks, after IO release, for IO to read high.
- `TB_CYCLES`, 400: clocks RST is held low with the clock running.
- `ATR_MIN`, 400: earliest legal ATR start bit, in clocks after RST goes high.
- `ATR_MAX`, 40000: latest legal ATR start bit.
- `CNT_W`, 16: timer width; must hold `ATR_MAX`.

Ports:
- `i_clk`, in, 1: single clock; all state changes on its rising edge.
- `i_rstn`, in, 1: reset, asynchronous, active-low.
- `i_cmd_activate`, in, 1: one-cycle pulse; start a cold activation.
- `i_cmd_warm_reset`, in, 1: one-cycle pulse; start a warm reset.
- `i_cmd_deactivate`, in, 1: one-cycle pulse; start deactivation.
- `i_io`, in, 1: IO line level, already synchronised.
- `o_vcc_en`, out, 1: card supply enable.
- `o_clk_en`, out, 1: card clock gate enable.
- `o_card_rst`, out, 1: card RST pin level (0 = card held in reset).
- `o_io_rel`, out, 1: 1 = IO pulled up/released; 0 = IO driven low.
- `o_active`, out, 1: ATR start bit accepted; the UART owns IO.
- `o_busy`, out, 1: state is neither IDLE nor ACTIVE.
- `o_done`, out, 1: one-cycle pulse on entry to ACTIVE.
- `o_err`, out, 2: 0 none, 1 IO stuck low, 2 ATR too early, 3 ATR timeout.
- `o_state`, out, 3: current state encoding.

## Operation
State encodings: IDLE=0, PWRUP=1, RSTLOW=2, ATRWAIT=3, ACTIVE=4, DEACT=5. A single `CNT_W`-bit timer `cnt` clears on every state entry, increments each cycle and saturates at all-ones.

- **IDLE.** All contact outputs are 0. `i_cmd_activate` clears `o_err` and moves to PWRUP.
- **PWRUP.** `o_vcc_en`=1; IO stays driven low. When `cnt`==`PWR_CYCLES`-1, move to RSTLOW.
- **RSTLOW.** `o_clk_en`=1, `o_io_rel`=1, `o_card_rst`=0.
  - The sticky flag `io_hi` sets on the first cycle `i_io`=1.
  - If `cnt`==`TA_CYCLES`-1 and `io_hi` is still 0, set `o_err`=1 and move to DEACT.
  - Otherwise, when `cnt`==`TB_CYCLES`-1, move to ATRWAIT.
- **ATRWAIT.** `o_card_rst`=1. A start bit is `i_io`=0 with the registered previous `i_io`=1.
  - Start bit with `cnt` < `ATR_MIN`: set `o_err`=2 and move to DEACT.
  - Start bit with `cnt` >= `ATR_MIN`: move to ACTIVE and pulse `o_done`.
  - `cnt`==`ATR_MAX` with no start bit: set `o_err`=3 and move to DEACT.
- **ACTIVE.** Contacts stay in the ATRWAIT configuration; `o_active`=1. `i_cmd_warm_reset` moves to RSTLOW; VCC and clock stay on, and `o_card_rst` drops the next cycle.
- **DEACT.** Four one-cycle steps, tracked by `cnt` 0..3:
  - step 0: `o_card_rst`=0;
  - step 1: `o_clk_en`=0;
  - step 2: `o_io_rel`=0;
  - step 3: `o_vcc_en`=0, then move to IDLE.
- **Command priority:** deactivate > warm_reset > activate.
  - Deactivate is accepted in any state except IDLE and DEACT.
  - Warm reset is accepted only in ACTIVE.
  - Activate is accepted only in IDLE.
  - All other commands are ignored, with no side effects.
- `o_err` holds until the next accepted activate.

## Timing
- **Reset values:** all outputs 0; state IDLE; `cnt`=0; `io_hi`=0.
- **Output registration:** all outputs are registered. Contact outputs change the cycle after the state change that causes them; there is no combinational path from command to output.
- **Latency:**
  - Activate pulse at edge N: `o_vcc_en`=1 at N+1; `o_clk_en`=1 at N+1+`PWR_CYCLES`.
  - `o_card_rst` rises `TB_CYCLES` later.
  - `o_done` follows the start-bit edge by 1 cycle.
- **Reset mid-operation:** asynchronous return to IDLE with all contacts 0. There is no graceful deactivation; the host must avoid this while VCC is on.
- **Simultaneous events:**
  - A timeout and a start bit in the same cycle count as a valid ATR.
  - A deactivate arriving in the same cycle as an error transition still goes to DEACT, and the error code is retained.

## Test plan
- **Cold activation, normal card.** Default parameters, activate at cycle 10, card releases IO at RSTLOW+50, start bit at 1000 clocks after RST high -> `o_vcc_en` at cycle 11, `o_clk_en` at cycle 27, `o_card_rst` rises at cycle 427, `o_done` pulse, `o_active`=1, `o_err`=0.
- **IO stuck low.** Same stimulus, but the card never releases IO -> `o_err`=1 after 200 RSTLOW cycles, then the 4-step DEACT order RST, CLK, IO, VCC, ending in IDLE.
- **Early ATR.** Start bit 100 clocks after RST high -> `o_err`=2, DEACT, `o_active` never asserted.
- **ATR timeout.** No start bit -> `o_err`=3 at `cnt`=40000, then DEACT.
- **Warm reset.** From ACTIVE, warm reset -> `o_vcc_en` and `o_clk_en` stay 1, `o_card_rst` low for 400 cycles, a new ATR gives `o_done`. An activate issued in ACTIVE is ignored.
- **Priority and async reset.** Warm reset and deactivate in the same cycle -> DEACT. `i_rstn` low in ATRWAIT -> all outputs 0 immediately.
